// File: rtl/ndro_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ndro_pkg : shared constants and parameter-legality helper for ndro_array
// Rev 1.0
// ---------------------------------------------------------------------------
package ndro_pkg;

  localparam int AGE_W         = 4;
  localparam int MODE_NDRO     = 0;
  localparam int MODE_DRO      = 1;
  localparam int SETUP_MAX     = (1 << AGE_W) - 1;
  localparam int OUT_DELAY_MIN = 1;

  function automatic bit params_ok(input int channels, input int destructive,
                                   input int setup_cyc, input int out_delay);
    return (channels >= 1) &&
           (destructive == MODE_NDRO || destructive == MODE_DRO) &&
           (setup_cyc >= 0) && (setup_cyc <= SETUP_MAX) &&
           (out_delay >= OUT_DELAY_MIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ndro_array_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ndro_array_if : per-channel set/clr, shared read strobe and readout bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface ndro_array_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] set;
  logic [CHANNELS-1:0] clr;
  logic                rd;
  logic                viol_clr;
  logic [CHANNELS-1:0] out;
  logic                out_valid;
  logic [CHANNELS-1:0] viol;

  modport master (
    output set, clr, rd, viol_clr,
    input  out, out_valid, viol
  );

  modport slave (
    input  set, clr, rd, viol_clr,
    output out, out_valid, viol
  );

endinterface
`default_nettype wire

// File: rtl/ndro_array_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ndro_cell : one storage bit with setup-age tracking and sticky violation flag
// Rev 1.0
// ---------------------------------------------------------------------------
module ndro_cell
  import ndro_pkg::*;
#(
  parameter int DESTRUCTIVE = 0,
  parameter int SETUP_CYC   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic clr,
  input  logic rd,
  input  logic viol_clr,
  output logic rd_bit,
  output logic viol
);

  localparam logic [AGE_W-1:0] SETUP_V = AGE_W'(SETUP_CYC);
  localparam bit               DRO     = (DESTRUCTIVE == MODE_DRO);
  localparam bit               CHECK   = (SETUP_CYC > 0);

  logic             state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             viol_q, viol_d;
  logic             write, collide, setup_err;

  always_comb begin
    write     = set | clr;
    collide   = set & clr;
    // a read coinciding with a write sees the old value but is still too early
    setup_err = rd && CHECK && (write || (age_q < SETUP_V));

    state_d = state_q;
    if (rd && DRO) state_d = 1'b0;
    if (set && !clr)      state_d = 1'b1;
    else if (clr && !set) state_d = 1'b0;

    if (write)                age_d = '0;
    else if (age_q < SETUP_V) age_d = age_q + AGE_W'(1);
    else                      age_d = age_q;

    if (collide || setup_err) viol_d = 1'b1;
    else if (viol_clr)        viol_d = 1'b0;
    else                      viol_d = viol_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= 1'b0;
      age_q   <= SETUP_V;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      viol_q  <= viol_d;
    end
  end

  assign rd_bit = state_q;
  assign viol   = viol_q;

endmodule
`default_nettype wire

// File: rtl/ndro_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ndro_array : CHANNELS NDRO/DRO cells sharing one read strobe and output delay
// Rev 1.0
// ---------------------------------------------------------------------------
module ndro_array
  import ndro_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DESTRUCTIVE = 0,
  parameter int SETUP_CYC   = 1,
  parameter int OUT_DELAY   = 1
) (
  input  logic         clk,
  input  logic         reset,
  ndro_array_if.slave  bus
);

  localparam int PW = CHANNELS + 1;

  generate
    if (!params_ok(CHANNELS, DESTRUCTIVE, SETUP_CYC, OUT_DELAY)) begin : g_param_err
      $error("ndro_array: illegal parameter combination");
    end
  endgenerate

  logic [CHANNELS-1:0] rd_bits;
  logic [CHANNELS-1:0] viol_bits;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
      ndro_cell #(
        .DESTRUCTIVE (DESTRUCTIVE),
        .SETUP_CYC   (SETUP_CYC)
      ) u_cell (
        .clk      (clk),
        .reset    (reset),
        .set      (bus.set[i]),
        .clr      (bus.clr[i]),
        .rd       (bus.rd),
        .viol_clr (bus.viol_clr),
        .rd_bit   (rd_bits[i]),
        .viol     (viol_bits[i])
      );
    end
  endgenerate

  // Stage data is zeroed when no read enters, so out is low whenever out_valid is low
  logic [PW-1:0] pipe_q [OUT_DELAY];
  logic [PW-1:0] pipe_d [OUT_DELAY];

  always_comb begin
    pipe_d[0] = bus.rd ? {1'b1, rd_bits} : '0;
    for (int s = 1; s < OUT_DELAY; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < OUT_DELAY; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign bus.out_valid = pipe_q[OUT_DELAY-1][CHANNELS];
  assign bus.out       = pipe_q[OUT_DELAY-1][CHANNELS-1:0];
  assign bus.viol      = viol_bits;

endmodule
`default_nettype wire

// File: tb/tb_ndro_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ndro_array : three configurations checked every cycle against a scheduled-readout model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ndro_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // config k: 0 = 1ch NDRO S1 D1, 1 = 4ch DRO S1 D1, 2 = 4ch NDRO S3 D3
  int p_ch  [3] = '{1, 4, 4};
  int p_dro [3] = '{0, 1, 0};
  int p_su  [3] = '{1, 1, 3};
  int p_dl  [3] = '{1, 1, 3};

  logic       s_rst [3];
  logic [3:0] s_set [3];
  logic [3:0] s_clr [3];
  logic       s_rd  [3];
  logic       s_vc  [3];

  logic [3:0] d_out  [3];
  logic [3:0] d_viol [3];
  logic       d_ov   [3];

  ndro_array_if #(.CHANNELS(1)) bus0 ();
  ndro_array_if #(.CHANNELS(4)) bus1 ();
  ndro_array_if #(.CHANNELS(4)) bus2 ();

  assign bus0.set      = s_set[0][0:0];
  assign bus0.clr      = s_clr[0][0:0];
  assign bus0.rd       = s_rd[0];
  assign bus0.viol_clr = s_vc[0];
  assign bus1.set      = s_set[1];
  assign bus1.clr      = s_clr[1];
  assign bus1.rd       = s_rd[1];
  assign bus1.viol_clr = s_vc[1];
  assign bus2.set      = s_set[2];
  assign bus2.clr      = s_clr[2];
  assign bus2.rd       = s_rd[2];
  assign bus2.viol_clr = s_vc[2];

  assign d_out[0]  = {3'b000, bus0.out};
  assign d_viol[0] = {3'b000, bus0.viol};
  assign d_ov[0]   = bus0.out_valid;
  assign d_out[1]  = bus1.out;
  assign d_viol[1] = bus1.viol;
  assign d_ov[1]   = bus1.out_valid;
  assign d_out[2]  = bus2.out;
  assign d_viol[2] = bus2.viol;
  assign d_ov[2]   = bus2.out_valid;

  ndro_array #(.CHANNELS(1), .DESTRUCTIVE(0), .SETUP_CYC(1), .OUT_DELAY(1)) dut0 (
    .clk(clk), .reset(s_rst[0]), .bus(bus0));
  ndro_array #(.CHANNELS(4), .DESTRUCTIVE(1), .SETUP_CYC(1), .OUT_DELAY(1)) dut1 (
    .clk(clk), .reset(s_rst[1]), .bus(bus1));
  ndro_array #(.CHANNELS(4), .DESTRUCTIVE(0), .SETUP_CYC(3), .OUT_DELAY(3)) dut2 (
    .clk(clk), .reset(s_rst[2]), .bus(bus2));

  // Model: stored bits, cycle of last write, sticky flags, and a schedule of read results by due cycle
  logic [3:0] m_state [3];
  logic [3:0] m_viol  [3];
  int         m_lastw [3][4];
  logic       m_sv    [3][8];
  logic [3:0] m_sb    [3][8];

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d edge=%0d: actual=%h required=%h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int e);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] cap;
      logic       st, cl, wr, late;
      int         slot;
      if (s_rst[k]) begin
        m_state[k] = '0;
        m_viol[k]  = '0;
        for (int i = 0; i < 4; i++) m_lastw[k][i] = -100;
        for (int j = 0; j < 8; j++) m_sv[k][j] = 1'b0;
      end else begin
        cap = m_state[k];
        for (int i = 0; i < p_ch[k]; i++) begin
          st   = s_set[k][i];
          cl   = s_clr[k][i];
          wr   = st | cl;
          late = s_rd[k] && (p_su[k] > 0) && (wr || (e - m_lastw[k][i] <= p_su[k]));
          if ((st && cl) || late) m_viol[k][i] = 1'b1;
          else if (s_vc[k])       m_viol[k][i] = 1'b0;
          if (s_rd[k] && p_dro[k] == 1) m_state[k][i] = 1'b0;
          if (st && !cl)      m_state[k][i] = 1'b1;
          else if (cl && !st) m_state[k][i] = 1'b0;
          if (wr) m_lastw[k][i] = e;
        end
        if (s_rd[k]) begin
          slot          = (e + p_dl[k] - 1) % 8;
          m_sv[k][slot] = 1'b1;
          m_sb[k][slot] = cap;
        end
      end
    end
  endtask

  task automatic compare(input int e);
    for (int k = 0; k < 3; k++) begin
      int   slot;
      logic ev;
      slot = e % 8;
      ev   = m_sv[k][slot];
      chk("out_valid", k, {3'b000, d_ov[k]}, {3'b000, ev});
      chk("out", k, d_out[k], ev ? m_sb[k][slot] : 4'h0);
      chk("viol", k, d_viol[k], m_viol[k]);
      m_sv[k][slot] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    int e;
    e = cyc;
    model_step(e);
    cyc++;
    #1;
    compare(e);
  end

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      s_rst[k] = 1'b0;
      s_set[k] = '0;
      s_clr[k] = '0;
      s_rd[k]  = 1'b0;
      s_vc[k]  = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input int k, input logic [3:0] st, input logic [3:0] cl,
                     input logic r, input logic vc);
    idle_all();
    s_set[k] = st;
    s_clr[k] = cl;
    s_rd[k]  = r;
    s_vc[k]  = vc;
    step();
  endtask

  initial begin
    idle_all();
    for (int k = 0; k < 3; k++) s_rst[k] = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_out", k, d_out[k], 4'h0);
      chk("rst_valid", k, {3'b000, d_ov[k]}, 4'h0);
      chk("rst_viol", k, d_viol[k], 4'h0);
    end
    idle_all();
    repeat (2) step();

    // basic NDRO sequence on the single-channel instance
    drv(0, 4'h1, 4'h0, 1'b0, 1'b0);
    drv(0, 4'h0, 4'h1, 1'b0, 1'b0);
    drv(0, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t1_rd_cleared", 0, d_out[0], 4'h0);
    chk("t1_valid", 0, {3'b000, d_ov[0]}, 4'h1);
    drv(0, 4'h1, 4'h0, 1'b0, 1'b0);
    drv(0, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t1_rd_set", 0, d_out[0], 4'h1);
    drv(0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t1_rd_again", 0, d_out[0], 4'h1);
    chk("t1_no_viol", 0, d_viol[0], 4'h0);

    // destructive readout
    drv(1, 4'b0100, 4'h0, 1'b0, 1'b0);
    drv(1, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(1, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t2_first_rd", 1, d_out[1], 4'b0100);
    drv(1, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t2_second_rd", 1, d_out[1], 4'b0000);
    chk("t2_second_valid", 1, {3'b000, d_ov[1]}, 4'h1);
    drv(1, 4'b0100, 4'h0, 1'b0, 1'b0);
    drv(1, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(1, 4'b0100, 4'h0, 1'b1, 1'b0);
    chk("t2_rd_set_old", 1, d_out[1], 4'b0100);
    chk("t2_rd_set_viol", 1, d_viol[1], 4'b0100);
    drv(1, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(1, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t2_set_wins", 1, d_out[1], 4'b0100);
    drv(1, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("t2_viol_clr", 1, d_viol[1], 4'h0);

    // set/clr collision
    drv(1, 4'b0001, 4'h0, 1'b0, 1'b0);
    drv(1, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(1, 4'b0001, 4'b0001, 1'b0, 1'b0);
    chk("t3_collide_viol", 1, d_viol[1], 4'b0001);
    drv(1, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("t3_viol_clr", 1, d_viol[1], 4'h0);
    drv(1, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t3_state_kept", 1, d_out[1], 4'b0001);

    // setup window of 3 cycles, output delay 3
    drv(2, 4'b0010, 4'h0, 1'b0, 1'b0);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(2, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t4_setup_viol", 2, d_viol[2], 4'b0010);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b1);
    drv(2, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t4_no_new_viol", 2, d_viol[2], 4'h0);
    chk("t4_late_out", 2, d_out[2], 4'b0010);

    // four back-to-back reads with changing contents
    drv(2, 4'h0, 4'hF, 1'b0, 1'b0);
    repeat (4) drv(2, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b1);
    drv(2, 4'b0001, 4'h0, 1'b1, 1'b0);
    drv(2, 4'b1000, 4'h0, 1'b1, 1'b0);
    drv(2, 4'h0, 4'b0001, 1'b1, 1'b0);
    chk("t5_snap0", 2, d_out[2], 4'b0000);
    chk("t5_valid0", 2, {3'b000, d_ov[2]}, 4'h1);
    drv(2, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t5_snap1", 2, d_out[2], 4'b0001);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("t5_snap2", 2, d_out[2], 4'b1001);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("t5_snap3", 2, d_out[2], 4'b1000);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("t5_end_valid", 2, {3'b000, d_ov[2]}, 4'h0);

    // reset while a read is in flight
    drv(2, 4'h0, 4'h0, 1'b1, 1'b0);
    idle_all();
    s_rst[2] = 1'b1;
    step();
    chk("t6_rst_viol", 2, d_viol[2], 4'h0);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("t6_dropped", 2, {3'b000, d_ov[2]}, 4'h0);
    drv(2, 4'h0, 4'h0, 1'b1, 1'b0);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b0);
    drv(2, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("t6_first_rd_valid", 2, {3'b000, d_ov[2]}, 4'h1);
    chk("t6_first_rd_out", 2, d_out[2], 4'h0);
    chk("t6_first_rd_viol", 2, d_viol[2], 4'h0);

    // randomized traffic on all three instances
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 3; k++) begin
        s_rst[k] = ($urandom_range(0, 49) == 0);
        s_set[k] = 4'($urandom) & 4'($urandom);
        s_clr[k] = 4'($urandom) & 4'($urandom);
        s_rd[k]  = ($urandom_range(0, 4) < 2);
        s_vc[k]  = ($urandom_range(0, 9) == 0);
      end
      step();
    end
    idle_all();
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
